// File: rtl/pwm_pkg.sv
// Register map constants for the multi-channel PWM block.
// No logic; shared by the top level and the channel slice.
// No flow control involved.
package pwm_pkg;
    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_PERIOD = 1;
    localparam int ADDR_STATUS = 2;
    localparam int ADDR_DUTY0  = 3;
    localparam int EN_BIT      = 0;
    localparam int POL_LSB     = 8;
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty, compare against the shared counter, polarity flop.
// Latency: one cycle from count to pwm_o; duty write visible on duty_o next cycle.
// No backpressure; bus writes always accepted.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_dat_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [CNT_W-1:0] duty_o,
    output logic             pwm_o
);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    // Active duty only moves on a load, so a running period never sees a half-applied write.
    always_comb begin
        duty_sh_d  = wr_en_i ? wr_dat_i : duty_sh_q;
        duty_act_d = load_i ? duty_sh_q : duty_act_q;
        pwm_d      = (en_i & (count_i < duty_act_q)) ^ pol_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign duty_o = duty_sh_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared period counter and double-buffered PERIOD/DUTY registers.
// Latency: count to pin one cycle; register writes take effect at the next period load.
// No backpressure on the bus. PWM_IRQ_EN adds the PEND flag and the period-end irq.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int NCH    = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bSel,
    input  logic              bWrite,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [31:0]       bWData,
    output logic [31:0]       bRData,
    output logic [NCH-1:0]    pwmOutput,
    output logic              irq
);

    logic                       en_q, en_d;
    logic [NCH-1:0]             pol_q, pol_d;
    logic [CNT_W-1:0]           per_sh_q, per_sh_d;
    logic [CNT_W-1:0]           per_act_q, per_act_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       we;
    logic                       wr_ctrl, wr_period;
    logic                       wrap, load;
    logic [NCH-1:0]             duty_wr;
    logic [NCH-1:0][CNT_W-1:0]  duty_sh;
    logic [31:0]                rdata;
    logic                       unused_wdata;

    assign unused_wdata = ^bWData;

    assign we        = bSel & bWrite;
    assign wr_ctrl   = we && (bAddr == ADDR_W'(ADDR_CTRL));
    assign wr_period = we && (bAddr == ADDR_W'(ADDR_PERIOD));

    // Loading while disabled keeps the active set fresh, so enabling starts from the latest writes.
    assign wrap = en_q && (count_q == per_act_q);
    assign load = wrap || !en_q;

    always_comb begin
        en_d      = en_q;
        pol_d     = pol_q;
        per_sh_d  = per_sh_q;
        per_act_d = load ? per_sh_q : per_act_q;
        count_d   = (en_q && !wrap) ? count_q + CNT_W'(1) : '0;
        if (wr_ctrl) begin
            en_d  = bWData[EN_BIT];
            pol_d = bWData[POL_LSB +: NCH];
        end
        if (wr_period) begin
            per_sh_d = bWData[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            pol_q     <= '0;
            per_sh_q  <= '1;
            per_act_q <= '1;
            count_q   <= '0;
        end else begin
            en_q      <= en_d;
            pol_q     <= pol_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            count_q   <= count_d;
        end
    end

`ifdef PWM_IRQ_EN
    logic pend_q, pend_d;
    logic clr_pend;

    assign clr_pend = we && (bAddr == ADDR_W'(ADDR_STATUS)) && bWData[0];

    // A wrap in the same cycle as a clear keeps PEND set.
    always_comb begin
        pend_d = wrap | (pend_q & ~clr_pend);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign irq = pend_q;
`else
    assign irq = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign duty_wr[i] = we && (bAddr == ADDR_W'(ADDR_DUTY0 + i));

        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .wr_en_i  (duty_wr[i]),
            .wr_dat_i (bWData[CNT_W-1:0]),
            .load_i   (load),
            .en_i     (en_q),
            .pol_i    (pol_q[i]),
            .count_i  (count_q),
            .duty_o   (duty_sh[i]),
            .pwm_o    (pwmOutput[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (bAddr == ADDR_W'(ADDR_CTRL)) begin
            rdata[EN_BIT]          = en_q;
            rdata[POL_LSB +: NCH]  = pol_q;
        end else if (bAddr == ADDR_W'(ADDR_PERIOD)) begin
            rdata[CNT_W-1:0] = per_sh_q;
        end
`ifdef PWM_IRQ_EN
        else if (bAddr == ADDR_W'(ADDR_STATUS)) begin
            rdata[0] = pend_q;
        end
`endif
        for (int i = 0; i < NCH; i++) begin
            if (bAddr == ADDR_W'(ADDR_DUTY0 + i)) begin
                rdata[CNT_W-1:0] = duty_sh[i];
            end
        end
    end

    assign bRData = rdata;

endmodule
